// File: rtl/conv_operand_loader.sv
// conv_operand_loader: loads kernel, window-1 and window-2 operands from one byte
// stream into register files, serves asynchronous reads, and handshakes with the engine.
`default_nettype none

module conv_operand_loader #(
  parameter int KERNEL_SIZE     = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_ADDR_WIDTH = 4,
  parameter int SRAM_DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_load,
  input  logic                       i_data_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_data_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_window_addr,
  output logic [DATA_WIDTH-1:0]      o_window1_data,
  output logic [DATA_WIDTH-1:0]      o_window2_data,
  input  logic [5:0]                 i_kernel_addr,
  output logic [DATA_WIDTH-1:0]      o_kernel_data,
  output logic                       o_conv_start,
  input  logic                       i_conv_done,
  output logic                       o_busy
);

  localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = $clog2(SRAM_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL_K    = 3'd1,
    S_FILL_W1   = 3'd2,
    S_FILL_W2   = 3'd3,
    S_START     = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            wr_k, wr_w1, wr_w2;

  logic [DATA_WIDTH-1:0] kern_mem [N];
  logic [DATA_WIDTH-1:0] w1_mem   [N];
  logic [DATA_WIDTH-1:0] w2_mem   [N];

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    o_data_ready = 1'b0;
    o_conv_start = 1'b0;
    o_busy       = 1'b1;
    wr_k         = 1'b0;
    wr_w1        = 1'b0;
    wr_w2        = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_load) begin
          state_nxt = S_FILL_K;
          count_nxt = '0;
        end
      end
      S_FILL_K, S_FILL_W1, S_FILL_W2: begin
        o_data_ready = 1'b1;
        if (i_data_valid) begin
          wr_k  = (state == S_FILL_K);
          wr_w1 = (state == S_FILL_W1);
          wr_w2 = (state == S_FILL_W2);
          // Last entry of an operand advances straight to the next one: no bubble.
          if (count == LAST) begin
            count_nxt = '0;
            case (state)
              S_FILL_K:  state_nxt = S_FILL_W1;
              S_FILL_W1: state_nxt = S_FILL_W2;
              default:   state_nxt = S_START;
            endcase
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      S_START: begin
        o_conv_start = 1'b1;
        state_nxt    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_conv_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        kern_mem[i] <= '0;
        w1_mem[i]   <= '0;
        w2_mem[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (count == CW'(i)) begin
          if (wr_k)  kern_mem[i] <= i_data;
          if (wr_w1) w1_mem[i]   <= i_data;
          if (wr_w2) w2_mem[i]   <= i_data;
        end
      end
    end
  end

  // Address decode by compare so out-of-range addresses fall through to zero.
  always_comb begin
    o_kernel_data  = '0;
    o_window1_data = '0;
    o_window2_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i_kernel_addr == 6'(i)) o_kernel_data = kern_mem[i];
      if (i_window_addr == SRAM_ADDR_WIDTH'(i)) begin
        o_window1_data = w1_mem[i];
        o_window2_data = w2_mem[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_operand_loader.sv
// Self-checking bench for conv_operand_loader: directed scenarios plus random loads
// compared against an index-based operand model.
`default_nettype none

module tb_conv_operand_loader;

  localparam int N  = 9;
  localparam int NB = 3 * N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, data_valid, conv_done;
  logic [7:0] data;
  logic       data_ready, conv_start, busy;
  logic [3:0] window_addr;
  logic [5:0] kernel_addr;
  logic [7:0] window1_data, window2_data, kernel_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_k  [N];
  logic [7:0] exp_w1 [N];
  logic [7:0] exp_w2 [N];
  logic [7:0] stream [NB];

  conv_operand_loader #(
    .KERNEL_SIZE(3), .DATA_WIDTH(8), .SRAM_ADDR_WIDTH(4), .SRAM_DEPTH(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_data_valid(data_valid),
    .i_data(data), .o_data_ready(data_ready), .i_window_addr(window_addr),
    .o_window1_data(window1_data), .o_window2_data(window2_data),
    .i_kernel_addr(kernel_addr), .o_kernel_data(kernel_data),
    .o_conv_start(conv_start), .i_conv_done(conv_done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepted beat number idx lands in operand idx/N at entry idx%N.
  task automatic model_store(input int idx, input logic [7:0] b);
    case (idx / N)
      0:       exp_k[idx % N]  = b;
      1:       exp_w1[idx % N] = b;
      default: exp_w2[idx % N] = b;
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      exp_k[i] = 8'h00; exp_w1[i] = 8'h00; exp_w2[i] = 8'h00;
    end
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      window_addr = 4'(a);
      kernel_addr = 6'(a);
      #1;
      check({tag, "_k"},  kernel_data,  (a < N) ? exp_k[a]  : 8'h00);
      check({tag, "_w1"}, window1_data, (a < N) ? exp_w1[a] : 8'h00);
      check({tag, "_w2"}, window2_data, (a < N) ? exp_w2[a] : 8'h00);
    end
    kernel_addr = 6'd63;
    #1;
    check({tag, "_k63"}, kernel_data, 8'h00);
    kernel_addr = 6'($urandom_range(16, 62));
    #1;
    check({tag, "_khi"}, kernel_data, 8'h00);
    window_addr = 4'd0;
    kernel_addr = 6'd0;
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random valid.
  task automatic fill(input int mode, input int stop_at, input bit done_noise);
    int acc;
    int cycles;
    bit v;
    acc = 0;
    cycles = 0;
    check("idle_busy", busy, 0);
    check("idle_ready", data_ready, 0);
    load = 1'b1;
    data_valid = 1'($urandom % 2);
    data = 8'hEE;
    step();
    load = 1'b0;
    while (acc < stop_at && cycles < 500) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = 1'($urandom % 2);
      endcase
      data_valid = v;
      data = v ? stream[acc] : 8'($urandom);
      conv_done = done_noise && (acc >= N) && (acc < 2 * N);
      check("fill_ready", data_ready, 1);
      check("fill_busy", busy, 1);
      check("fill_start", conv_start, 0);
      step();
      cycles++;
      if (v) begin
        model_store(acc, stream[acc]);
        acc++;
      end
    end
    data_valid = 1'b0;
    conv_done = 1'b0;
    if (acc < stop_at) check("fill_timeout", acc, stop_at);
  endtask

  task automatic expect_start();
    check("start_pulse", conv_start, 1);
    check("start_ready", data_ready, 0);
    check("start_busy", busy, 1);
    step();
    check("wait_start", conv_start, 0);
    check("wait_busy", busy, 1);
    check("wait_ready", data_ready, 0);
  endtask

  task automatic release_done();
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    check("done_busy", busy, 0);
    check("done_start", conv_start, 0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data_valid = 1'b0; conv_done = 1'b0;
    data = 8'h00; window_addr = 4'd0; kernel_addr = 6'd0;
    model_clear();
    #23;
    check("rst_busy", busy, 0);
    check("rst_ready", data_ready, 0);
    check("rst_start", conv_start, 0);
    sweep("rst");
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back 1..27
    for (int i = 0; i < NB; i++) stream[i] = 8'(i + 1);
    fill(0, NB, 1'b0);
    expect_start();
    sweep("t1");

    // Junk in WAIT_DONE must be ignored
    load = 1'b1; data_valid = 1'b1; data = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t3_ready", data_ready, 0);
      check("t3_busy", busy, 1);
      check("t3_start", conv_start, 0);
    end
    load = 1'b0; data_valid = 1'b0;
    sweep("t3");
    release_done();

    // Random contents first so the toggled reload is observable
    for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
    fill(2, NB, 1'b0);
    expect_start();
    release_done();
    for (int i = 0; i < NB; i++) stream[i] = 8'(i + 1);
    fill(1, NB, 1'b0);
    expect_start();
    sweep("t2");
    release_done();

    // conv_done in IDLE and during FILL_W1
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    check("t6_idle_busy", busy, 0);
    check("t6_idle_start", conv_start, 0);
    for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
    fill(0, NB, 1'b1);
    expect_start();
    sweep("t6");
    release_done();

    // Reset after the 12th beat
    for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
    fill(0, 12, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("t5_busy", busy, 0);
    check("t5_ready", data_ready, 0);
    check("t5_start", conv_start, 0);
    sweep("t5");
    step();
    check("t5_hold_start", conv_start, 0);
    rst_n = 1'b1;
    step();
    check("t5_post_busy", busy, 0);
    fill(0, NB, 1'b0);
    expect_start();
    sweep("t5r");
    release_done();

    // Random loads with random valid and idle gaps
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
      fill(2, NB, 1'($urandom % 2));
      expect_start();
      sweep("rnd");
      release_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
